cvmcu_obi_instr_responder: RTL
==============================

# cvmcu_obi_instr_responder

OBI 1.2 subordinate (responder) that terminates the instruction/data OBI port of the CV-MCU core inside the DV harness. It provides a word-addressed backing memory, accepts pipelined requests up to a bounded outstanding depth, and returns in-order responses after a fixed latency with `rready` back-pressure. The block is the memory-side counterpart of the core's OBI initiator, and the existing OBI interface assertions apply to its port unchanged.

## Interface
- `ADDR_WIDTH`, 32: OBI address width.
- `DATA_WIDTH`, 32: OBI data width; fixed at 32, so `be` is 4 bits.
- `MEM_DEPTH`, 1024: backing memory size in 32-bit words; must be a power of 2.
- `BASE_ADDR`, 32'h1C00_0000: byte address of word 0.
- `MAX_OUTSTANDING`, 4: response FIFO depth; legal range 1..16.
- `RSP_LATENCY`, 1: cycles from the accept edge to the earliest `rvalid`; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous assert, active-low reset; deassertion is synchronous to `clk` externally.
- `req`  in  1  request valid.
- `gnt`  out  1  request grant.
- `addr`  in  ADDR_WIDTH  byte address.
- `we`  in  1  1 = write, 0 = read.
- `be`  in  4  byte enables.
- `wdata`  in  32  write data.
- `rvalid`  out  1  response valid.
- `rready`  in  1  initiator accepts the response.
- `rdata`  out  32  read data; 0 for writes and errors.
- `err`  out  1  response error flag.
- `outstanding`  out  $clog2(MAX_OUTSTANDING+1)  accepted transactions whose responses are not yet popped.

## Operation
- Accept: a transaction is accepted on a rising edge when `req && gnt`.
- `gnt = reset_n && (count < MAX_OUTSTANDING)`. `gnt` depends only on registered state, never on `req`. A pop in the same cycle does not raise `gnt` while full.
- Decode: `idx = (addr - BASE_ADDR) >> 2`.
  - Error when `addr < BASE_ADDR`, `addr >= BASE_ADDR + 4*MEM_DEPTH`, or `addr[1:0] != 0`.
  - An error response has `err=1` and `rdata=0`, and the memory is not modified.
- Write: on the accept edge, `mem[idx]` byte lane i is updated where `be[i]=1`. `be=0` is legal and leaves memory unchanged. The response has `rdata=0`, `err=0`.
- Read: `rdata` is captured from `mem[idx]` on the accept edge, so it reflects every write accepted on earlier edges. `be` is ignored.
- Response FIFO: each entry holds {`rdata`, `err`, `age`}.
  - `age` is loaded with 1 on push and increments each edge, saturating at `RSP_LATENCY`.
- `rvalid = !empty && head.age >= RSP_LATENCY`. `rdata` and `err` come directly from the head entry.
- Once `rvalid` is high, it and `rdata`/`err` stay stable until `rvalid && rready`; that edge pops the head.
- Responses return strictly in acceptance order.
- Count: `count_next = count + accept - pop`. Simultaneous accept and pop leaves `count` unchanged. `outstanding = count`.
- Memory is not reset; contents are X until written.

## Timing
- Reset values while `reset_n` is low: `gnt=0`, `rvalid=0`, `rdata=0`, `err=0`, `outstanding=0`. The FIFO is empty and all ages are cleared.
- First edge after reset release: `gnt=1`.
- Reset mid-operation: all outstanding transactions are discarded with no response. Memory writes already accepted persist.
- Latency, with acceptance at edge k and `rready=1`:
  - `rvalid` is high in the cycle after edge k+RSP_LATENCY-1.
  - With `RSP_LATENCY=1`, `rvalid` is high in the cycle immediately following the grant cycle.
- Back-to-back: with `rready=1` and `RSP_LATENCY=1`, the block sustains one accept and one response per cycle indefinitely.
- Full: after `MAX_OUTSTANDING` accepts with no pop, `gnt=0`. `gnt` returns to 1 in the cycle after the first pop edge.
- Ageing: an entry behind a stalled head keeps ageing. When the head pops, the next entry is presented in the following cycle if its age has already saturated.

## Test plan
- Write then read, `RSP_LATENCY=1`: write `addr=BASE_ADDR+0x10`, `wdata=32'hDEAD_BEEF`, `be=4'hF`, then read the same address on the next cycle.
  - Required: responses on consecutive cycles; `rdata=0`/`err=0` for the write, then `32'hDEAD_BEEF`/`err=0` for the read.
- Byte enables: location holds `32'hDEAD_BEEF`; write `32'h1122_3344` with `be=4'b0101`, then read.
  - Required: read returns `32'hDE22_BE44`.
- Errors: read at `BASE_ADDR-4`, at `BASE_ADDR+4*MEM_DEPTH`, and at `BASE_ADDR+2`.
  - Required: three responses with `err=1`, `rdata=0`; a following legal read of a known location returns its unchanged value.
- Back-pressure and full, `MAX_OUTSTANDING=4`, `rready=0`: drive 6 reads.
  - Required: `gnt` is 1 for 4 accepts then 0; `outstanding=4`; `rvalid` and `rdata` are held stable.
  - Raising `rready` yields 6 in-order responses; `gnt` returns 1 one cycle after the first pop.
- Latency, `RSP_LATENCY=3`: accept a single read at edge k.
  - Required: `rvalid` first high in the cycle after edge k+2, never earlier; `outstanding` reads 1 then returns to 0 after the pop.
- Reset mid-flight: drop `reset_n` with 3 reads outstanding.
  - Required: all outputs reach their reset values immediately; no stale `rvalid` after release; `gnt=1` at the first edge after release.

Source files
------------

// File: rtl/cvmcu_obi_instr_responder.sv
// OBI 1.2 subordinate for the CV-MCU DV harness: word-addressed backing memory
// with an in-order, fixed-latency response FIFO and rready back-pressure.
module cvmcu_obi_instr_responder #(
    parameter int unsigned             ADDR_WIDTH      = 32,
    parameter int unsigned             DATA_WIDTH      = 32,
    parameter int unsigned             MEM_DEPTH       = 1024,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR       = 32'h1C00_0000,
    parameter int unsigned             MAX_OUTSTANDING = 4,
    parameter int unsigned             RSP_LATENCY     = 1,
    localparam int unsigned            CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req,
    output logic                      gnt,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic                      we,
    input  logic [DATA_WIDTH/8-1:0]   be,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      err,
    output logic [CNT_W-1:0]          outstanding
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned AGE_W = 4;
    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    // One extra bit so the upper bound cannot wrap near the top of the address map.
    localparam logic [ADDR_WIDTH:0]  BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0]  LIMIT_EXT = BASE_EXT + ((ADDR_WIDTH + 1)'(MEM_DEPTH) << 2);
    localparam logic [AGE_W-1:0]     LAT       = AGE_W'(RSP_LATENCY);
    localparam logic [CNT_W-1:0]     MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0]     LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);

    logic [DATA_WIDTH-1:0] mem_r       [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_r [MAX_OUTSTANDING];
    logic                  fifo_err_r  [MAX_OUTSTANDING];
    logic [AGE_W-1:0]      fifo_age_r  [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;

    logic                  accept_s;
    logic                  pop_s;
    logic                  rvalid_s;
    logic                  addr_err_s;
    logic [IDX_W-1:0]      idx_s;
    logic [DATA_WIDTH-1:0] rsp_data_s;
    logic                  rsp_err_s;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NBYTES-1:0]     lanes
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Grant depends only on registered occupancy so it never combinationally follows req.
    assign gnt         = reset_n && (count_r < MAX_CNT);
    assign accept_s    = req && gnt;
    assign rvalid_s    = (count_r != {CNT_W{1'b0}}) && (fifo_age_r[rd_ptr_r] >= LAT);
    assign pop_s       = rvalid_s && rready;
    assign outstanding = count_r;
    assign rvalid      = rvalid_s;

    // Address decode: range and alignment check plus word index.
    always_comb begin
        addr_err_s = ({1'b0, addr} < BASE_EXT) || ({1'b0, addr} >= LIMIT_EXT) ||
                     (addr[1:0] != 2'b00);
        idx_s      = IDX_W'((addr - BASE_ADDR) >> 2);
    end

    // Response payload captured at the accept edge.
    always_comb begin
        rsp_data_s = {DATA_WIDTH{1'b0}};
        rsp_err_s  = 1'b0;
        if (addr_err_s) begin
            rsp_err_s = 1'b1;
        end else if (we) begin
            rsp_data_s = {DATA_WIDTH{1'b0}};
        end else begin
            rsp_data_s = mem_r[idx_s];
        end
    end

    // Head presentation; masked to zero whenever no response is offered.
    always_comb begin
        rdata = {DATA_WIDTH{1'b0}};
        err   = 1'b0;
        if (rvalid_s) begin
            rdata = fifo_data_r[rd_ptr_r];
            err   = fifo_err_r[rd_ptr_r];
        end else begin
            rdata = {DATA_WIDTH{1'b0}};
            err   = 1'b0;
        end
    end

    // Backing memory: deliberately not reset so contents survive a harness reset.
    always_ff @(posedge clk) begin
        if (accept_s && we && !addr_err_s) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], wdata, be);
        end
    end

    // Outstanding transaction count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (accept_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
        end
    end

    // FIFO entries; every slot ages each edge so entries behind a stalled head mature.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                fifo_data_r[i] <= {DATA_WIDTH{1'b0}};
                fifo_err_r[i]  <= 1'b0;
                fifo_age_r[i]  <= {AGE_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                if (fifo_age_r[i] < LAT) begin
                    fifo_age_r[i] <= fifo_age_r[i] + AGE_W'(1);
                end
            end
            if (accept_s) begin
                fifo_data_r[wr_ptr_r] <= rsp_data_s;
                fifo_err_r[wr_ptr_r]  <= rsp_err_s;
                fifo_age_r[wr_ptr_r]  <= AGE_W'(1);
            end
        end
    end

endmodule
